ibuf: RTL and testbench

IBUF -- requirements
Module: ibuf

---
 rtl/ibuf_pkg.sv | 24 ++
 rtl/ibuf_if.sv | 47 ++++
 rtl/ibuf.sv | 133 +++++++++++++
 tb/tb_ibuf.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibuf_pkg.sv
// ibuf_pkg: shared definitions for the instruction buffer that sits between
// fetch and decode.
//   excp_t       - fetch exception code carried with an instruction
//   ibuf_entry_t - one buffered instruction with its prediction and exception
package ibuf_pkg;

  typedef enum logic [2:0] {
    EXCP_NONE = 3'd0,
    ADEF      = 3'd1,
    TLBR      = 3'd2,
    PIF       = 3'd3,
    PPI       = 3'd4
  } excp_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        excp;
    excp_t       excp_type;
  } ibuf_entry_t;

endpackage

// File: rtl/ibuf_if.sv
// ibuf_if: fetch-side and decode-side signals of the instruction buffer.
//   Fetch side : input_size, pc0/1, inst0/1, pred_br_taken0/1,
//                pred_br_target0/1, have_excp, excp_type -> buffer; i_ready <- buffer
//   Control    : flush (pipeline redirect)
//   Decode side: o_valid, o_pc0/1, o_inst0/1, o_pred_taken0/1,
//                o_pred_target0/1, o_excp0/1, o_excp_type0/1 <- buffer; o_pop -> buffer
// Modports: slave is the buffer's view, master is the environment's view.
interface ibuf_if;
  import ibuf_pkg::*;

  logic [1:0]  input_size;
  logic [31:0] pc0, pc1;
  logic [31:0] inst0, inst1;
  logic        pred_br_taken0, pred_br_taken1;
  logic [31:0] pred_br_target0, pred_br_target1;
  logic        have_excp;
  excp_t       excp_type;
  logic        i_ready;
  logic        flush;
  logic [1:0]  o_valid;
  logic [31:0] o_pc0, o_pc1;
  logic [31:0] o_inst0, o_inst1;
  logic        o_pred_taken0, o_pred_taken1;
  logic [31:0] o_pred_target0, o_pred_target1;
  logic        o_excp0, o_excp1;
  excp_t       o_excp_type0, o_excp_type1;
  logic [1:0]  o_pop;

  modport slave (
    input  input_size, pc0, pc1, inst0, inst1,
           pred_br_taken0, pred_br_taken1, pred_br_target0, pred_br_target1,
           have_excp, excp_type, flush, o_pop,
    output i_ready, o_valid, o_pc0, o_pc1, o_inst0, o_inst1,
           o_pred_taken0, o_pred_taken1, o_pred_target0, o_pred_target1,
           o_excp0, o_excp1, o_excp_type0, o_excp_type1
  );

  modport master (
    output input_size, pc0, pc1, inst0, inst1,
           pred_br_taken0, pred_br_taken1, pred_br_target0, pred_br_target1,
           have_excp, excp_type, flush, o_pop,
    input  i_ready, o_valid, o_pc0, o_pc1, o_inst0, o_inst1,
           o_pred_taken0, o_pred_taken1, o_pred_target0, o_pred_target1,
           o_excp0, o_excp1, o_excp_type0, o_excp_type1
  );

endinterface

// File: rtl/ibuf.sv
// ibuf: circular instruction buffer, up to two writes and two reads per cycle.
// Ports:
//   clk   - sole clock, rising edge
//   reset - synchronous active-high reset (wins over flush)
//   bus   - ibuf_if.slave, fetch/decode handshake and entry fields
// Parameter DEPTH: entry count, power of two, at least 8.
// Optional feature (macro IBUF_PERF_CNT_EN): adds perf_full_cycles and
// perf_empty_cycles outputs, 32-bit wrapping counters.
module ibuf
  import ibuf_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  ibuf_if.slave       bus
`ifdef IBUF_PERF_CNT_EN
  ,
  output logic [31:0] perf_full_cycles,
  output logic [31:0] perf_empty_cycles
`endif
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  localparam int AW = $clog2(DEPTH) + 1;
  localparam int IW = AW - 1;

  ibuf_entry_t   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] count;
  logic [IW-1:0] wr_idx0, wr_idx1, rd_idx0, rd_idx1;
  logic          we0, we1;
  logic          ready;
  ibuf_entry_t   entry0, entry1, head0, head1;

  assign count   = wr_ptr_q - rd_ptr_q;
  assign wr_idx0 = wr_ptr_q[IW-1:0];
  assign wr_idx1 = wr_idx0 + IW'(1);
  assign rd_idx0 = rd_ptr_q[IW-1:0];
  assign rd_idx1 = rd_idx0 + IW'(1);

  // Leave room for the fetch issued this cycle plus one already in flight.
  assign ready = (count <= AW'(DEPTH - 4));

  assign we0 = !bus.flush && (bus.input_size != 2'd0);
  assign we1 = !bus.flush && (bus.input_size == 2'd2);

  // Exceptions from fetch belong to the first instruction of the packet only.
  always_comb begin
    entry0             = '0;
    entry0.pc          = bus.pc0;
    entry0.inst        = bus.inst0;
    entry0.pred_taken  = bus.pred_br_taken0;
    entry0.pred_target = bus.pred_br_target0;
    entry0.excp        = bus.have_excp;
    entry0.excp_type   = bus.excp_type;
    entry1             = '0;
    entry1.pc          = bus.pc1;
    entry1.inst        = bus.inst1;
    entry1.pred_taken  = bus.pred_br_taken1;
    entry1.pred_target = bus.pred_br_target1;
    entry1.excp        = 1'b0;
    entry1.excp_type   = EXCP_NONE;
  end

  // Storage has no reset; stale contents are never visible because o_valid
  // is derived from the pointers.
  always_ff @(posedge clk) begin
    if (we0) mem_q[wr_idx0] <= entry0;
    if (we1) mem_q[wr_idx1] <= entry1;
  end

  // Flush discards everything, including this cycle's writes and pops.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + AW'(bus.input_size);
      rd_ptr_d = rd_ptr_q + AW'(bus.o_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign head0 = mem_q[rd_idx0];
  assign head1 = mem_q[rd_idx1];

  assign bus.i_ready        = ready;
  assign bus.o_valid        = {count >= AW'(2), count >= AW'(1)};
  assign bus.o_pc0          = head0.pc;
  assign bus.o_pc1          = head1.pc;
  assign bus.o_inst0        = head0.inst;
  assign bus.o_inst1        = head1.inst;
  assign bus.o_pred_taken0  = head0.pred_taken;
  assign bus.o_pred_taken1  = head1.pred_taken;
  assign bus.o_pred_target0 = head0.pred_target;
  assign bus.o_pred_target1 = head1.pred_target;
  assign bus.o_excp0        = head0.excp;
  assign bus.o_excp1        = head1.excp;
  assign bus.o_excp_type0   = head0.excp_type;
  assign bus.o_excp_type1   = head1.excp_type;

`ifdef IBUF_PERF_CNT_EN
  logic [31:0] perf_full_q, perf_empty_q;

  // Stall and starvation counters; a flush cycle is not counted as empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_full_q  <= '0;
      perf_empty_q <= '0;
    end else begin
      if (!ready) perf_full_q <= perf_full_q + 32'd1;
      if ((count == '0) && !bus.flush) perf_empty_q <= perf_empty_q + 32'd1;
    end
  end

  assign perf_full_cycles  = perf_full_q;
  assign perf_empty_cycles = perf_empty_q;
`endif

endmodule

// File: tb/tb_ibuf.sv
// tb_ibuf: self-checking bench for ibuf (DEPTH = 16).
// A directed vector table covers the basic write/pop/flush behaviour; hand
// sequences cover exceptions, filling, pointer wrap, flush and reset. A
// queue of expected entries supplies reference values for the sequences.
// Define IBUF_PERF_CNT_EN to also exercise the performance counters.
module tb_ibuf;
  import ibuf_pkg::*;

  localparam int DEPTH = 16;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  ibuf_entry_t modelQ[$];

  ibuf_if bus ();

`ifdef IBUF_PERF_CNT_EN
  logic [31:0] perfFull, perfEmpty;
`endif

  ibuf #(.DEPTH(DEPTH)) dut (
    .clk               (clk),
    .reset             (reset),
    .bus               (bus)
`ifdef IBUF_PERF_CNT_EN
    ,
    .perf_full_cycles  (perfFull),
    .perf_empty_cycles (perfEmpty)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Protocol assertions: never overfill, never pop what is not valid.
  always @(posedge clk) begin
    if (!reset && !bus.flush) begin
      assert (bus.input_size <= 2'd2 && int'(bus.input_size) <= DEPTH - modelQ.size())
        else $error("[TB] protocol violation: input_size %0d with %0d free", bus.input_size, DEPTH - modelQ.size());
      assert (int'(bus.o_pop) <= ((modelQ.size() >= 2) ? 2 : modelQ.size()))
        else $error("[TB] protocol violation: o_pop %0d with %0d entries", bus.o_pop, modelQ.size());
    end
  end

  function automatic logic [31:0] instOf(input logic [31:0] pc);
    return pc ^ 32'h1f40_0000;
  endfunction

  function automatic ibuf_entry_t mkEntry(input logic [31:0] pc, input logic excp, input excp_t etype);
    ibuf_entry_t e;
    e.pc          = pc;
    e.inst        = instOf(pc);
    e.pred_taken  = pc[3];
    e.pred_target = pc + 32'h40;
    e.excp        = excp;
    e.excp_type   = etype;
    return e;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic setIdle();
    bus.input_size      = 2'd0;
    bus.pc0             = '0;
    bus.pc1             = '0;
    bus.inst0           = '0;
    bus.inst1           = '0;
    bus.pred_br_taken0  = 1'b0;
    bus.pred_br_taken1  = 1'b0;
    bus.pred_br_target0 = '0;
    bus.pred_br_target1 = '0;
    bus.have_excp       = 1'b0;
    bus.excp_type       = EXCP_NONE;
    bus.flush           = 1'b0;
    bus.o_pop           = 2'd0;
  endtask

  task automatic doReset(input logic withFlush);
    setIdle();
    bus.flush      = withFlush;
    bus.input_size = withFlush ? 2'd2 : 2'd0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    setIdle();
    modelQ.delete();
  endtask

  // One clock of stimulus; the model is updated after the edge.
  task automatic applyStimulus(input logic [1:0] size, input logic [31:0] pc, input logic excp,
                               input excp_t etype, input logic [1:0] pop, input logic fl);
    bus.input_size      = size;
    bus.pc0             = pc;
    bus.pc1             = pc + 32'd4;
    bus.inst0           = instOf(pc);
    bus.inst1           = instOf(pc + 32'd4);
    bus.pred_br_taken0  = pc[3];
    bus.pred_br_taken1  = bus.pc1[3];
    bus.pred_br_target0 = pc + 32'h40;
    bus.pred_br_target1 = pc + 32'h44;
    bus.have_excp       = excp;
    bus.excp_type       = etype;
    bus.o_pop           = pop;
    bus.flush           = fl;
    @(posedge clk);
    #1;
    if (fl) begin
      modelQ.delete();
    end else begin
      for (int k = 0; k < int'(pop); k++) void'(modelQ.pop_front());
      if (size >= 2'd1) modelQ.push_back(mkEntry(pc, excp, etype));
      if (size == 2'd2) modelQ.push_back(mkEntry(pc + 32'd4, 1'b0, EXCP_NONE));
    end
    setIdle();
  endtask

  task automatic checkOutput(input string tag);
    int n;
    n = modelQ.size();
    checkVal({tag, ".valid"}, 32'(bus.o_valid), {30'd0, n >= 2, n >= 1});
    checkVal({tag, ".ready"}, 32'(bus.i_ready), 32'(n <= DEPTH - 4));
    if (n >= 1) begin
      checkVal({tag, ".pc0"}, bus.o_pc0, modelQ[0].pc);
      checkVal({tag, ".inst0"}, bus.o_inst0, modelQ[0].inst);
      checkVal({tag, ".ptaken0"}, 32'(bus.o_pred_taken0), 32'(modelQ[0].pred_taken));
      checkVal({tag, ".ptarget0"}, bus.o_pred_target0, modelQ[0].pred_target);
      checkVal({tag, ".excp0"}, 32'(bus.o_excp0), 32'(modelQ[0].excp));
    end
    if (n >= 2) begin
      checkVal({tag, ".pc1"}, bus.o_pc1, modelQ[1].pc);
      checkVal({tag, ".inst1"}, bus.o_inst1, modelQ[1].inst);
      checkVal({tag, ".excp1"}, 32'(bus.o_excp1), 32'(modelQ[1].excp));
    end
  endtask

  typedef struct {
    logic [1:0]  size;
    logic [31:0] pc;
    logic [1:0]  pop;
    logic        fl;
    logic [1:0]  expValid;
    logic [31:0] expPc0;
    logic [31:0] expPc1;
    logic        expReady;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [31:0] nextPc;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    setIdle();

    vecs[0]  = '{2'd2, 32'h1c00_0000, 2'd0, 1'b0, 2'b11, 32'h1c00_0000, 32'h1c00_0004, 1'b1};
    vecs[1]  = '{2'd1, 32'h1c00_0008, 2'd1, 1'b0, 2'b11, 32'h1c00_0004, 32'h1c00_0008, 1'b1};
    vecs[2]  = '{2'd0, 32'h0000_0000, 2'd2, 1'b0, 2'b00, 32'h0,         32'h0,         1'b1};
    vecs[3]  = '{2'd1, 32'h1c00_0010, 2'd0, 1'b0, 2'b01, 32'h1c00_0010, 32'h0,         1'b1};
    vecs[4]  = '{2'd2, 32'h1c00_0014, 2'd1, 1'b0, 2'b11, 32'h1c00_0014, 32'h1c00_0018, 1'b1};
    vecs[5]  = '{2'd0, 32'h0000_0000, 2'd1, 1'b0, 2'b01, 32'h1c00_0018, 32'h0,         1'b1};
    vecs[6]  = '{2'd1, 32'h1c00_001c, 2'd1, 1'b0, 2'b01, 32'h1c00_001c, 32'h0,         1'b1};
    vecs[7]  = '{2'd2, 32'h1c00_0020, 2'd0, 1'b0, 2'b11, 32'h1c00_001c, 32'h1c00_0020, 1'b1};
    vecs[8]  = '{2'd2, 32'h1c00_0028, 2'd2, 1'b0, 2'b11, 32'h1c00_0024, 32'h1c00_0028, 1'b1};
    vecs[9]  = '{2'd2, 32'h1c00_0030, 2'd1, 1'b1, 2'b00, 32'h0,         32'h0,         1'b1};
    vecs[10] = '{2'd1, 32'h1c00_0040, 2'd0, 1'b0, 2'b01, 32'h1c00_0040, 32'h0,         1'b1};
    vecs[11] = '{2'd0, 32'h0000_0000, 2'd1, 1'b0, 2'b00, 32'h0,         32'h0,         1'b1};

    // Reset state.
    doReset(1'b0);
    checkVal("reset.valid", 32'(bus.o_valid), 32'd0);
    checkVal("reset.ready", 32'(bus.i_ready), 32'd1);

    // Directed vector table.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].size, vecs[i].pc, 1'b0, EXCP_NONE, vecs[i].pop, vecs[i].fl);
      checkVal($sformatf("vec%0d.valid", i), 32'(bus.o_valid), 32'(vecs[i].expValid));
      checkVal($sformatf("vec%0d.ready", i), 32'(bus.i_ready), 32'(vecs[i].expReady));
      if (vecs[i].expValid[0]) checkVal($sformatf("vec%0d.pc0", i), bus.o_pc0, vecs[i].expPc0);
      if (vecs[i].expValid[1]) checkVal($sformatf("vec%0d.pc1", i), bus.o_pc1, vecs[i].expPc1);
    end

    // Exception on slot 0 only.
    doReset(1'b0);
    applyStimulus(2'd1, 32'h1c00_0000, 1'b1, ADEF, 2'd0, 1'b0);
    checkVal("excp.valid", 32'(bus.o_valid), 32'd1);
    checkVal("excp.excp0", 32'(bus.o_excp0), 32'd1);
    checkVal("excp.type0", 32'(bus.o_excp_type0), 32'(ADEF));
    checkVal("excp.inst0", bus.o_inst0, 32'h0340_0000);
    applyStimulus(2'd2, 32'h1c00_0004, 1'b1, PIF, 2'd1, 1'b0);
    checkOutput("excpPair");
    checkVal("excpPair.type0", 32'(bus.o_excp_type0), 32'(PIF));

    // Fill without popping: ready drops at 13, in-flight fetch still lands.
    doReset(1'b0);
    nextPc = 32'h1c00_1000;
    for (int i = 0; i < 13; i++) begin
      applyStimulus(2'd1, nextPc, 1'b0, EXCP_NONE, 2'd0, 1'b0);
      nextPc += 32'd4;
      checkOutput($sformatf("fill%0d", i + 1));
    end
    checkVal("fill.readyAt13", 32'(bus.i_ready), 32'd0);
    applyStimulus(2'd2, nextPc, 1'b0, EXCP_NONE, 2'd0, 1'b0);
    nextPc += 32'd8;
    checkOutput("fill15");
    applyStimulus(2'd1, nextPc, 1'b0, EXCP_NONE, 2'd0, 1'b0);
    nextPc += 32'd4;
    checkOutput("fill16");
    applyStimulus(2'd0, 32'h0, 1'b0, EXCP_NONE, 2'd2, 1'b0);
    checkOutput("fillPop14");
    applyStimulus(2'd2, nextPc, 1'b0, EXCP_NONE, 2'd2, 1'b0);
    nextPc += 32'd8;
    checkOutput("fillWrPop14");
    for (int i = 0; i < 7; i++) begin
      applyStimulus(2'd0, 32'h0, 1'b0, EXCP_NONE, 2'd2, 1'b0);
      checkOutput($sformatf("drain%0d", i));
    end

    // Steady stream with odd alignment so pairs straddle the wrap point.
    doReset(1'b0);
    nextPc = 32'h1c00_2000;
    applyStimulus(2'd1, nextPc, 1'b0, EXCP_NONE, 2'd0, 1'b0);
    nextPc += 32'd4;
    applyStimulus(2'd2, nextPc, 1'b0, EXCP_NONE, 2'd0, 1'b0);
    nextPc += 32'd8;
    checkOutput("wrapPre");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(2'd2, nextPc, 1'b0, EXCP_NONE, 2'd2, 1'b0);
      nextPc += 32'd8;
      checkOutput($sformatf("wrap%0d", i));
      checkVal($sformatf("wrap%0d.seq", i), bus.o_pc0, 32'h1c00_2000 + 32'(8 * (i + 1)));
    end

    // Flush with entries, a write and a pop in the same cycle.
    doReset(1'b0);
    nextPc = 32'h1c00_3000;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2'd2, nextPc, 1'b0, EXCP_NONE, 2'd0, 1'b0);
      nextPc += 32'd8;
    end
    applyStimulus(2'd1, nextPc, 1'b0, EXCP_NONE, 2'd0, 1'b0);
    nextPc += 32'd4;
    checkVal("preFlush.valid", 32'(bus.o_valid), 32'd3);
    applyStimulus(2'd2, 32'h1c00_3f00, 1'b0, EXCP_NONE, 2'd1, 1'b1);
    checkVal("flush.valid", 32'(bus.o_valid), 32'd0);
    checkVal("flush.ready", 32'(bus.i_ready), 32'd1);
    applyStimulus(2'd1, 32'h1c00_4000, 1'b0, EXCP_NONE, 2'd0, 1'b0);
    checkOutput("postFlush");
    checkVal("postFlush.pc0", bus.o_pc0, 32'h1c00_4000);

    // Reset wins over a simultaneous flush and write.
    applyStimulus(2'd2, 32'h1c00_5000, 1'b0, EXCP_NONE, 2'd0, 1'b0);
    doReset(1'b1);
    checkVal("resetFlush.valid", 32'(bus.o_valid), 32'd0);
    checkVal("resetFlush.ready", 32'(bus.i_ready), 32'd1);

`ifdef IBUF_PERF_CNT_EN
    // One empty cycle, climb to 14, five ready-low cycles, drain, two more
    // empty cycles, then a flush while empty that must not count.
    doReset(1'b0);
    nextPc = 32'h1c00_6000;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(2'd2, nextPc, 1'b0, EXCP_NONE, 2'd0, 1'b0);
      nextPc += 32'd8;
    end
    for (int i = 0; i < 4; i++) applyStimulus(2'd0, 32'h0, 1'b0, EXCP_NONE, 2'd0, 1'b0);
    for (int i = 0; i < 7; i++) applyStimulus(2'd0, 32'h0, 1'b0, EXCP_NONE, 2'd2, 1'b0);
    for (int i = 0; i < 2; i++) applyStimulus(2'd0, 32'h0, 1'b0, EXCP_NONE, 2'd0, 1'b0);
    applyStimulus(2'd0, 32'h0, 1'b0, EXCP_NONE, 2'd0, 1'b1);
    checkVal("perf.full", perfFull, 32'd5);
    checkVal("perf.empty", perfEmpty, 32'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
